// File: rtl/control_multiciclo.sv
// Multicycle RV32I control FSM: sequences ALU, register unit, PC and one shared memory port.
// Optional macro PERF_COUNTERS_EN adds the CycleCnt/InstRet performance counters.
module control_multiciclo #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [6:0] Opcode,
  input  logic [2:0] Funct3,
  input  logic       Funct7_5,
  input  logic       NextPCSrc,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemIsInstr,
  output logic       IRWr,
  output logic       PCWr,
  output logic       PCSrc,
  output logic       RUWr,
  output logic       DMWr,
  output logic [2:0] DMCtrl,
  output logic       ALUASrc,
  output logic       ALUBSrc,
  output logic [3:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic [4:0] BrOp,
  output logic [1:0] RUDataWrSrc,
  output logic [3:0] State,
  output logic       Fault
`ifdef PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstRet
`endif
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;
  logic              w_timeout;
  logic              w_is_load;
  logic              w_is_jal;

  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign w_is_load = (Opcode == OP_LOAD);
  assign w_is_jal  = (Opcode == OP_JAL);
  assign State     = r_state;
  assign Fault     = r_fault;

  // The wait counter restarts on every state change, so each memory state gets a fresh budget.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_wait <= '0;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (MemReady) begin
            if (r_state == S_FETCH)       r_state <= S_DECODE;
            else if (r_state == S_MEM_RD) r_state <= S_WB_MEM;
            else                          r_state <= S_FETCH;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_fault <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          case (Opcode)
            OP_R, OP_I, OP_LUI, OP_AUIPC: r_state <= S_EXEC;
            OP_LOAD, OP_STORE:            r_state <= S_MEM_ADDR;
            OP_BR:                        r_state <= S_BRANCH;
            OP_JAL, OP_JALR:              r_state <= S_JUMP;
            default: begin
              r_state <= S_TRAP;
              r_fault <= 1'b1;
            end
          endcase
        end
        S_EXEC:     r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= w_is_load ? S_MEM_RD : S_MEM_WR;
        S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_TRAP:     r_state <= S_TRAP;
        default: begin
          r_state <= S_TRAP;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  // Outputs follow the registered state; only IRWr and the store's PCWr look at MemReady.
  always_comb begin
    MemReq      = 1'b0;
    MemIsInstr  = 1'b0;
    IRWr        = 1'b0;
    PCWr        = 1'b0;
    PCSrc       = 1'b0;
    RUWr        = 1'b0;
    DMWr        = 1'b0;
    DMCtrl      = 3'b000;
    ALUASrc     = 1'b0;
    ALUBSrc     = 1'b0;
    ALUOp       = 4'b0000;
    ImmSrc      = 3'b000;
    BrOp        = 5'b00000;
    RUDataWrSrc = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemReq     = 1'b1;
        MemIsInstr = 1'b1;
        IRWr       = MemReady;
      end
      S_EXEC: begin
        ALUASrc = (Opcode == OP_AUIPC);
        ALUBSrc = (Opcode != OP_R);
        ImmSrc  = ((Opcode == OP_LUI) || (Opcode == OP_AUIPC)) ? 3'b011 : 3'b000;
        if (Opcode == OP_R)      ALUOp = {Funct7_5, Funct3};
        else if (Opcode == OP_I) ALUOp = {Funct7_5 & (Funct3 == 3'b101), Funct3};
      end
      S_MEM_ADDR: begin
        ALUBSrc = 1'b1;
        ImmSrc  = w_is_load ? 3'b000 : 3'b001;
        DMCtrl  = Funct3;
      end
      S_MEM_RD: begin
        MemReq = 1'b1;
        DMCtrl = Funct3;
      end
      S_MEM_WR: begin
        MemReq = 1'b1;
        DMWr   = 1'b1;
        DMCtrl = Funct3;
        PCWr   = MemReady;
      end
      S_WB_ALU: begin
        RUWr = 1'b1;
        PCWr = 1'b1;
      end
      S_WB_MEM: begin
        RUWr        = 1'b1;
        RUDataWrSrc = 2'b01;
        PCWr        = 1'b1;
      end
      S_BRANCH: begin
        ALUASrc = 1'b1;
        ALUBSrc = 1'b1;
        ImmSrc  = 3'b010;
        BrOp    = {1'b1, Funct3};
        PCWr    = 1'b1;
        PCSrc   = NextPCSrc;
      end
      S_JUMP: begin
        RUWr        = 1'b1;
        RUDataWrSrc = 2'b10;
        PCWr        = 1'b1;
        PCSrc       = 1'b1;
        ALUASrc     = w_is_jal;
        ImmSrc      = w_is_jal ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
  end

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_ret;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_ret  <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP)) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (PCWr) r_inst_ret <= r_inst_ret + CNT_W'(1);
    end
  end

  assign CycleCnt = r_cycle_cnt;
  assign InstRet  = r_inst_ret;
`endif

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: an instruction-level model expands each directed
// instruction into its expected per-cycle outputs, and one process compares every cycle.
module tb_control_multiciclo;
  localparam int TO = 16;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic [2:0] Funct3 = 3'd0;
  logic       Funct7_5 = 1'b0;
  logic       NextPCSrc = 1'b0;
  logic       MemReady = 1'b0;
  logic       MemReq, MemIsInstr, IRWr, PCWr, PCSrc, RUWr, DMWr;
  logic [2:0] DMCtrl;
  logic       ALUASrc, ALUBSrc;
  logic [3:0] ALUOp;
  logic [2:0] ImmSrc;
  logic [4:0] BrOp;
  logic [1:0] RUDataWrSrc;
  logic [3:0] State;
  logic       Fault;
`ifdef PERF_COUNTERS_EN
  logic [31:0] CycleCnt, InstRet;
`endif

  control_multiciclo dut (
    .Clk(Clk), .Rst_n(Rst_n), .Opcode(Opcode), .Funct3(Funct3), .Funct7_5(Funct7_5),
    .NextPCSrc(NextPCSrc), .MemReady(MemReady), .MemReq(MemReq), .MemIsInstr(MemIsInstr),
    .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RUWr(RUWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .BrOp(BrOp),
    .RUDataWrSrc(RUDataWrSrc), .State(State), .Fault(Fault)
`ifdef PERF_COUNTERS_EN
    , .CycleCnt(CycleCnt), .InstRet(InstRet)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mreq, minstr, irwr, pcwr, pcsrc, ruwr, dmwr;
    logic [2:0] dmctrl;
    logic       asrc, bsrc;
    logic [3:0] aluop;
    logic [2:0] imm;
    logic [4:0] brop;
    logic [1:0] wsrc;
    logic       fault;
  } obs_t;

  typedef struct {
    obs_t        e;
    logic [31:0] ir;
    logic        rdy;
    logic        rst_n;
    logic        taken;
  } step_t;

  step_t       q[$];
  logic [31:0] m_ir = 32'd0;
  logic        m_taken = 1'b0;
  obs_t        exp_cur, act;
  logic        exp_valid = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          n_pcwr_dut = 0;
  int          n_pcwr_model = 0;

  function automatic void check_eq(input string name, input int a, input int b);
    total++;
    if (a != b) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, a, b);
    end
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e;
    e       = '0;
    e.st    = st;
    e.fault = (st == 4'd15);
    return e;
  endfunction

  function automatic void push(input obs_t e, input logic rdy, input logic rst);
    step_t s;
    s.e = e; s.ir = m_ir; s.rdy = rdy; s.rst_n = rst; s.taken = m_taken;
    q.push_back(s);
  endfunction

  function automatic void model_reset();
    push(blank(4'd0), 1'b0, 1'b0);
    push(blank(4'd0), 1'b1, 1'b0);
    push(blank(4'd0), 1'b1, 1'b1);
  endfunction

  function automatic void model_trap(input int n);
    for (int i = 0; i < n; i++) push(blank(4'd15), 1'($urandom_range(0, 1)), 1'b1);
  endfunction

  // Memory wait: wait_n stalled cycles then a completing one; 16 stalls end in TRAP.
  // Returns 0 done, 1 trapped, 2 aborted (caller applies reset).
  function automatic int mem_phase(input obs_t e_wait, input obs_t e_done,
                                   input int wait_n, input int abort_at);
    for (int i = 0; i <= TO; i++) begin
      if (i == abort_at) return 2;
      if (i == TO) begin
        model_trap(3);
        return 1;
      end
      if (i < wait_n) push(e_wait, 1'b0, 1'b1);
      else begin
        push(e_done, 1'b1, 1'b1);
        return 0;
      end
    end
    return 1;
  endfunction

  function automatic void model_instr(input logic [31:0] ir, input int fetch_wait,
                                      input int mem_wait, input logic taken, input int abort_at);
    obs_t e, e2;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7;
    m_ir = ir; m_taken = taken;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[30];
    e = blank(4'd1); e.mreq = 1'b1; e.minstr = 1'b1;
    e2 = e; e2.irwr = 1'b1;
    if (mem_phase(e, e2, fetch_wait, -1) != 0) return;
    push(blank(4'd2), 1'b1, 1'b1);
    case (op)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: begin
        e = blank(4'd3);
        e.asrc = (op == 7'b0010111);
        e.bsrc = (op != 7'b0110011);
        e.imm  = (op == 7'b0110111 || op == 7'b0010111) ? 3'd3 : 3'd0;
        if (op == 7'b0110011) e.aluop = {f7, f3};
        else if (op == 7'b0010011) e.aluop = {f7 && (f3 == 3'd5), f3};
        push(e, 1'b1, 1'b1);
        e = blank(4'd7); e.ruwr = 1'b1; e.pcwr = 1'b1;
        push(e, 1'b1, 1'b1);
      end
      7'b0000011, 7'b0100011: begin
        e = blank(4'd4); e.bsrc = 1'b1; e.dmctrl = f3;
        e.imm = (op == 7'b0100011) ? 3'd1 : 3'd0;
        push(e, 1'b1, 1'b1);
        if (op == 7'b0000011) begin
          e = blank(4'd5); e.mreq = 1'b1; e.dmctrl = f3;
          if (mem_phase(e, e, mem_wait, abort_at) != 0) return;
          e = blank(4'd8); e.ruwr = 1'b1; e.wsrc = 2'd1; e.pcwr = 1'b1;
          push(e, 1'b1, 1'b1);
        end else begin
          e = blank(4'd6); e.mreq = 1'b1; e.dmwr = 1'b1; e.dmctrl = f3;
          e2 = e; e2.pcwr = 1'b1;
          if (mem_phase(e, e2, mem_wait, abort_at) != 0) return;
        end
      end
      7'b1100011: begin
        e = blank(4'd9); e.asrc = 1'b1; e.bsrc = 1'b1; e.imm = 3'd2;
        e.brop = {1'b1, f3}; e.pcwr = 1'b1; e.pcsrc = taken;
        push(e, 1'b1, 1'b1);
      end
      7'b1101111, 7'b1100111: begin
        e = blank(4'd10); e.ruwr = 1'b1; e.wsrc = 2'd2; e.pcwr = 1'b1; e.pcsrc = 1'b1;
        e.asrc = (op == 7'b1101111);
        e.imm  = (op == 7'b1101111) ? 3'd4 : 3'd0;
        push(e, 1'b1, 1'b1);
      end
      default: model_trap(3);
    endcase
  endfunction

  // Single compare process: every cycle with a model entry is checked mid-cycle.
  always @(negedge Clk) begin
    if (exp_valid) begin
      act = {State, MemReq, MemIsInstr, IRWr, PCWr, PCSrc, RUWr, DMWr, DMCtrl,
             ALUASrc, ALUBSrc, ALUOp, ImmSrc, BrOp, RUDataWrSrc, Fault};
      total++;
      if (act !== exp_cur) begin
        bad++;
        $display("FAIL cycle%0d outputs: got %h (state %0d), want %h (state %0d)",
                 cyc, act, act.st, exp_cur, exp_cur.st);
      end
      if (act.pcwr === 1'b1) begin
        n_pcwr_dut++;
        $display("cycle %0d: retire in state %0d, PCSrc=%0b RUWr=%0b", cyc, act.st, act.pcsrc, act.ruwr);
      end
      if (exp_cur.pcwr) n_pcwr_model++;
      cyc++;
    end
  end

  initial begin
    int n0;
    model_reset();
    n0 = q.size(); model_instr(32'h00500513, 0, 0, 1'b1, -1);
    check_eq("addi_len", q.size() - n0, 4);
    n0 = q.size(); model_instr(32'h00052583, 0, 3, 1'b0, -1);
    check_eq("lw_len", q.size() - n0, 8);
    check_eq("lw_wsrc", int'(q[q.size()-1].e.wsrc), 1);
    check_eq("lw_ruwr", int'(q[q.size()-1].e.ruwr), 1);
    n0 = q.size(); model_instr(32'h00000463, 0, 0, 1'b1, -1);
    check_eq("beq_len", q.size() - n0, 3);
    check_eq("beq_pcsrc", int'(q[q.size()-1].e.pcsrc), 1);
    model_instr(32'h003100b3, 0, 0, 1'b1, -1);
    model_instr(32'h403100b3, 0, 0, 1'b0, -1);
    n0 = q.size(); model_instr(32'h40315093, 0, 0, 1'b0, -1);
    check_eq("srai_aluop", int'(q[n0+2].e.aluop), 13);
    n0 = q.size(); model_instr(32'h40017093, 0, 0, 1'b0, -1);
    check_eq("andi_aluop", int'(q[n0+2].e.aluop), 7);
    model_instr(32'h123450b7, 0, 0, 1'b1, -1);
    model_instr(32'h00001097, 0, 0, 1'b1, -1);
    n0 = q.size(); model_instr(32'h00B52223, 2, 0, 1'b0, -1);
    check_eq("sw_len", q.size() - n0, 6);
    model_instr(32'h00209463, 0, 0, 1'b0, -1);
    n0 = q.size(); model_instr(32'h010000ef, 0, 0, 1'b0, -1);
    check_eq("jal_len", q.size() - n0, 3);
    model_instr(32'h00008067, 0, 0, 1'b0, -1);
    model_instr(32'h00055583, 0, 1, 1'b0, -1);
    n0 = q.size(); model_instr(32'h00000000, 0, 0, 1'b0, -1);
    check_eq("illegal_trap", int'(q[n0+2].e.st), 15);
    model_reset();
    n0 = q.size(); model_instr(32'h00500513, 16, 0, 1'b0, -1);
    check_eq("timeout_last_fetch", int'(q[n0+15].e.st), 1);
    check_eq("timeout_trap", int'(q[n0+16].e.st), 15);
    model_reset();
    model_instr(32'h00052583, 0, 20, 1'b0, -1);
    model_reset();
    model_instr(32'h00B52223, 0, 5, 1'b0, 2);
    model_reset();
    model_instr(32'h00500513, 0, 0, 1'b0, -1);

    foreach (q[i]) begin
      @(posedge Clk);
      #1;
      Rst_n     = q[i].rst_n;
      MemReady  = q[i].rdy;
      NextPCSrc = q[i].taken;
      Opcode    = q[i].ir[6:0];
      Funct3    = q[i].ir[14:12];
      Funct7_5  = q[i].ir[30];
      exp_cur   = q[i].e;
      exp_valid = 1'b1;
    end
    @(posedge Clk);
    #1;
    exp_valid = 1'b0;
    @(negedge Clk);
    check_eq("pcwr_pulses", n_pcwr_dut, n_pcwr_model);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
